// File: rtl/cmp_swap_32bit_pipe_if.sv
// Handshake bundle for the compare-and-swap stage: operand pair in, ordered pair plus flags out.
interface cmp_swap_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic             out_lt;
    logic             out_eq;
    logic             out_swapped;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_lt, out_eq, out_swapped
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_min, out_max, out_lt, out_eq, out_swapped
    );
endinterface

// File: rtl/cmp_swap_32bit_pipe.sv
// Two-stage pipelined unsigned compare-and-swap with valid/ready backpressure.
// Optional saturating swap counter enabled by defining CMP_SWAP_CNT_EN.
module cmp_swap_32bit_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    cmp_swap_if.slave        bus
`ifdef CMP_SWAP_CNT_EN
    ,
    output logic [CNT_W-1:0] swap_count
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) return cnt;
        return cnt + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] min_p2;
    logic [WIDTH-1:0] max_p2;
    logic             lt_p2;
    logic             eq_p2;
    logic             swp_p2;

    logic             adv_p1;
    logic             adv_p2;
    logic             lt_c;
    logic             eq_c;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv_p2 = ~vld_p2 | bus.out_ready;
    assign adv_p1 = ~vld_p1 | adv_p2;
    assign bus.in_ready = adv_p1;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && bus.in_valid) begin
            a_p1 <= bus.in_a;
            b_p1 <= bus.in_b;
        end
    end

    // ---- stage 2: compare and order ----
    assign lt_c = (a_p1 < b_p1);
    assign eq_c = (a_p1 == b_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            min_p2 <= '0;
            max_p2 <= '0;
            lt_p2  <= 1'b0;
            eq_p2  <= 1'b0;
            swp_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                min_p2 <= lt_c ? a_p1 : b_p1;
                max_p2 <= lt_c ? b_p1 : a_p1;
                lt_p2  <= lt_c;
                eq_p2  <= eq_c;
                swp_p2 <= ~lt_c & ~eq_c;
            end
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.out_min     = min_p2;
    assign bus.out_max     = max_p2;
    assign bus.out_lt      = lt_p2;
    assign bus.out_eq      = eq_p2;
    assign bus.out_swapped = swp_p2;

`ifdef CMP_SWAP_CNT_EN
    // ---- swap counter: counts completed output transfers that swapped ----
    logic [CNT_W-1:0] cnt_p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p3 <= '0;
        end else if (vld_p2 && bus.out_ready && swp_p2) begin
            cnt_p3 <= sat_inc(cnt_p3);
        end
    end

    assign swap_count = cnt_p3;
`endif

endmodule
